// File: rtl/multicycle_main_fsm.sv
// Main-decoder FSM for the multicycle core: fetch/decode/execute/memory/writeback sequencing.
// Define MC_PERF_CNT_EN to build the instr_count/cycle_count performance counters.
module multicycle_main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  state_t state, state_nxt;

  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DECODE && Op == 2'b11) illegal <= 1'b1;
    end
  end

  // Unused encodings fall through the default arm and recover to FETCH.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = UNKNOWN;
        endcase
      end
      MEMADR:   state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_nxt = mem_ready ? FETCH : MEMWRITE;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      MEMWB:    state_nxt = FETCH;
      ALUWB:    state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      UNKNOWN:  state_nxt = UNKNOWN;
      default:  state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    ResultSrc = 2'd0;
    ALUOp     = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
      end
      DECODE: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
      end
      MEMADR:   ALUSrcB = 2'd1;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'd1;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'd1;
        ALUOp   = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        Branch    = 1'b1;
      end
      default: ;
    endcase
    // Strobes stay quiet for the whole reset assertion, whatever state is held.
    if (reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (state == FETCH && mem_ready) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
